// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a persistent extension (E) flag.
// Single-cycle ops (logic, add, add-with-carry, complement, circulate, E-complement)
// complete one cycle after the start edge. MUL runs an unsigned shift-add
// multiply that takes WIDTH cycles. The controller sends one op per start pulse
// and waits for done.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             e,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_ADC = 3'b010,
    OP_CMA = 3'b011,
    OP_CIR = 3'b100,
    OP_CIL = 3'b101,
    OP_MUL = 3'b110,
    OP_CME = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Counter must hold 0..WIDTH-1 (the iteration index during MUL).
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  op_t                op_dec;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last_iter;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_e;
  logic [WIDTH:0]     sum;

  assign op_dec = op_t'(op);

  // Single-cycle datapath: result and next E for every non-multiply op.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_e   = e;
    case (op_dec)
      OP_AND: begin
        alu_res = a & b;
        alu_e   = 1'b0;
      end
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_e   = sum[WIDTH];
      end
      OP_ADC: begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, e};
        alu_res = sum[WIDTH-1:0];
        alu_e   = sum[WIDTH];
      end
      OP_CMA: begin
        alu_res = ~a;
      end
      OP_CIR: begin
        alu_res = {e, a[WIDTH-1:1]};
        alu_e   = a[0];
      end
      OP_CIL: begin
        alu_res = {a[WIDTH-2:0], e};
        alu_e   = a[WIDTH-1];
      end
      OP_CME: begin
        alu_res = a;
        alu_e   = ~e;
      end
      default: begin
        alu_res = '0;
        alu_e   = e;
      end
    endcase
  end

  // One shift-add step: the multiplier LSB decides whether the shifted multiplicand is added.
  always_comb begin
    acc_next  = mplier[0] ? (acc + mcand) : acc;
    last_iter = (count == CW'(WIDTH - 1));
  end

  // Control FSM: issue single-cycle ops directly, sequence the multiply, and pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result    <= '0;
      result_hi <= '0;
      e         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_dec == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              count  <= '0;
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              e         <= alu_e;
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_iter) begin
            result    <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
            e         <= |acc_next[2*WIDTH-1:WIDTH];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
